// File: rtl/icache_assoc.sv
// Set-associative I-cache: combinational 0-cycle hit; a miss fills a block word by word, then does one atomic line write.
// Fill stalls on iwait; pcRST/iflush abort a fill; iflush invalidates all lines at the next edge.
module icache_assoc #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        pcRST,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int WO = $clog2(WORDS);
  localparam int WB = (WORDS > 1) ? WO : 1;
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - WO - IB;
  localparam logic [31:0] BLK_MASK = ~(32'(WORDS * 4) - 32'd1);

  // CPUID only picks the memory-controller slot outside; it is checked here with the rest.
  if (SETS < 2 || (SETS & (SETS - 1)) != 0 || (WAYS != 1 && WAYS != 2) ||
      WORDS < 1 || (WORDS & (WORDS - 1)) != 0 || CPUID < 0) begin : g_bad_params
    $error("icache_assoc: illegal parameter set");
  end

  typedef enum logic {IDLE, FILL} state_t;

  logic          valid [WAYS][SETS];
  logic [TB-1:0] tags  [WAYS][SETS];
  logic [31:0]   data  [WAYS][SETS][WORDS];
  logic          lru   [SETS];
  logic [31:0]   buffer [WORDS];

  state_t        state;
  logic [31:0]   base;
  logic          vway;
  logic [WB-1:0] k;

  logic [WB-1:0] wsel;
  logic [IB-1:0] idx, fidx;
  logic [TB-1:0] tag, ftag;
  logic          hit_way, victim, abort, last, fill_done;

  assign wsel = WB'((imemaddr >> 2) & 32'(WORDS - 1));
  assign idx  = IB'(imemaddr >> (2 + WO));
  assign tag  = TB'(imemaddr >> (2 + WO + IB));
  assign fidx = IB'(base >> (2 + WO));
  assign ftag = TB'(base >> (2 + WO + IB));

  assign abort     = pcRST | iflush;
  assign last      = (k == WB'(WORDS - 1));
  assign fill_done = (state == FILL) && !iwait && last && !abort;

  always_comb begin
    ihit     = 1'b0;
    hit_way  = 1'b0;
    imemload = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (imemREN && valid[w][idx] && tags[w][idx] == tag) begin
        ihit     = 1'b1;
        hit_way  = 1'(w);
        imemload = data[w][idx][wsel];
      end
    end
  end

  // Lowest invalid way wins; otherwise fall back to the LRU way.
  always_comb begin
    victim = (WAYS == 2) ? lru[idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][idx]) victim = 1'(w);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      base  <= '0;
      vway  <= 1'b0;
      k     <= '0;
      iREN  <= 1'b0;
      iaddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !ihit && !pcRST && !iflush) begin
            state <= FILL;
            base  <= imemaddr & BLK_MASK;
            vway  <= victim;
            k     <= '0;
            iREN  <= 1'b1;
            iaddr <= imemaddr & BLK_MASK;
          end
        end
        FILL: begin
          if (abort || (!iwait && last)) begin
            state <= IDLE;
            k     <= '0;
            iREN  <= 1'b0;
            iaddr <= '0;
          end else if (!iwait) begin
            k     <= k + 1'b1;
            iaddr <= iaddr + 32'd4;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        lru[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) valid[w][s] <= 1'b0;
      end
    end else if (iflush) begin
      for (int s = 0; s < SETS; s++) begin
        lru[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) valid[w][s] <= 1'b0;
      end
    end else begin
      if (ihit && WAYS == 2) lru[idx] <= ~hit_way;
      if (fill_done) begin
        valid[vway][fidx] <= 1'b1;
        if (WAYS == 2) lru[fidx] <= ~vway;
      end
    end
  end

  // The final word bypasses the buffer so the whole line lands in one edge.
  always_ff @(posedge CLK) begin
    if (state == FILL && !iwait) buffer[k] <= iload;
    if (fill_done) begin
      tags[vway][fidx] <= ftag;
      for (int j = 0; j < WORDS; j++)
        data[vway][fidx][j] <= (j == int'(k)) ? iload : buffer[j];
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc at default parameters: directed scenarios plus randomized accesses vs. a block-level model.
module tb_icache_assoc;

  logic        CLK = 1'b0;
  logic        nRST, imemREN, pcRST, iflush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;

  int vectors = 0;
  int miscompares = 0;

  // Model: which memory block (addr>>3) each way of each set holds, -1 if empty.
  int blk_of [8][2];
  int lru_of [8];

  always #5 CLK = ~CLK;

  icache_assoc dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .pcRST(pcRST), .iflush(iflush), .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 200000", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[17:2] - 16'd15;
    return {16'hAAAA ^ a[31:16], lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      lru_of[s] = 0;
      for (int w = 0; w < 2; w++) blk_of[s][w] = -1;
    end
  endtask

  function automatic int model_way(input logic [31:0] a);
    int s, b;
    b = int'(a >> 3);
    s = b % 8;
    for (int w = 0; w < 2; w++) if (blk_of[s][w] == b) return w;
    return -1;
  endfunction

  task automatic model_touch(input logic [31:0] a, input int w);
    lru_of[int'(a >> 3) % 8] = 1 - w;
  endtask

  task automatic model_install(input logic [31:0] a);
    int s, v;
    s = int'(a >> 3) % 8;
    if (blk_of[s][0] < 0) v = 0;
    else if (blk_of[s][1] < 0) v = 1;
    else v = lru_of[s];
    blk_of[s][v] = int'(a >> 3);
    lru_of[s] = 1 - v;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Look up without letting the cycle reach an edge with imemREN high.
  task automatic probe(input logic [31:0] a, input logic exp_hit, input string tag);
    imemREN = 1'b1; imemaddr = a;
    #1;
    chk(tag, ihit, exp_hit);
    if (exp_hit) chk({tag, "_data"}, imemload, mem_word(a));
    else chk({tag, "_zero"}, imemload, 32'h0);
    imemREN = 1'b0;
    #1;
  endtask

  task automatic pulse_flush();
    imemREN = 1'b0; iflush = 1'b1;
    tick();
    iflush = 1'b0;
    model_clear();
  endtask

  task automatic access(input logic [31:0] a, input int smin, input int smax);
    int w, n;
    logic [31:0] base, wa;
    imemREN = 1'b1; imemaddr = a; pcRST = 1'b0; iflush = 1'b0; iwait = 1'b0;
    #1;
    w = model_way(a);
    if (w >= 0) begin
      chk("hit", ihit, 1'b1);
      chk("hit_data", imemload, mem_word(a));
      model_touch(a, w);
      tick();
    end else begin
      chk("miss", ihit, 1'b0);
      chk("miss_load", imemload, 32'h0);
      tick();
      base = a & ~32'h7;
      for (int kk = 0; kk < 2; kk++) begin
        wa = base + 32'(4 * kk);
        n = int'($urandom_range(smax, smin));
        for (int s = 0; s < n; s++) begin
          iwait = 1'b1; iload = 32'hDEAD_BEEF;
          #1;
          chk("stall_iren", iREN, 1'b1);
          chk("stall_iaddr", iaddr, wa);
          chk("stall_nohit", ihit, 1'b0);
          tick();
        end
        iwait = 1'b0; iload = mem_word(wa);
        #1;
        chk("fill_iren", iREN, 1'b1);
        chk("fill_iaddr", iaddr, wa);
        tick();
      end
      model_install(a);
      #1;
      chk("fill_hit", ihit, 1'b1);
      chk("fill_hit_data", imemload, mem_word(a));
      model_touch(a, model_way(a));
      tick();
    end
    imemREN = 1'b0;
  endtask

  initial begin
    nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; pcRST = 1'b0;
    iflush = 1'b0; iwait = 1'b0; iload = 32'h0;
    model_clear();
    #1 nRST = 1'b0;
    #1;
    chk("rst_iren", iREN, 1'b0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_ihit", ihit, 1'b0);
    chk("rst_imemload", imemload, 32'h0);
    imemREN = 1'b0;
    tick();
    nRST = 1'b1;
    tick();

    // Cold miss, then the second word of the same block.
    access(32'h40, 0, 0);
    imemREN = 1'b1; imemaddr = 32'h44;
    #1;
    chk("cold_w1_hit", ihit, 1'b1);
    chk("cold_w1_data", imemload, 32'hAAAA0002);
    imemREN = 1'b0;
    #1;
    access(32'h44, 0, 0);

    // LRU replacement.
    access(32'h80, 0, 0);
    access(32'h40, 0, 0);
    access(32'hC0, 0, 0);
    probe(32'h40, 1'b1, "lru_40_kept");
    probe(32'h80, 1'b0, "lru_80_evicted");
    probe(32'hC0, 1'b1, "lru_C0_in");

    // Flush with 0x40 and 0x80 resident.
    access(32'h40, 0, 0);
    access(32'h80, 0, 0);
    probe(32'h40, 1'b1, "pre_flush_40");
    probe(32'h80, 1'b1, "pre_flush_80");
    pulse_flush();
    probe(32'h40, 1'b0, "flush_40_gone");
    probe(32'h80, 1'b0, "flush_80_gone");
    access(32'h40, 0, 0);
    access(32'h80, 0, 0);
    access(32'hC0, 0, 0);
    probe(32'h40, 1'b0, "flush_way0_replaced");

    // Three stall cycles before each word.
    access(32'h100, 3, 3);

    // pcRST abort after word 0.
    pulse_flush();
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    chk("abort_miss", ihit, 1'b0);
    tick();
    iload = mem_word(32'h40);
    #1;
    chk("abort_w0_iaddr", iaddr, 32'h40);
    tick();
    pcRST = 1'b1;
    #1;
    chk("abort_w1_iaddr", iaddr, 32'h44);
    tick();
    pcRST = 1'b0; imemREN = 1'b0;
    #1;
    chk("abort_iren", iREN, 1'b0);
    chk("abort_iaddr", iaddr, 32'h0);
    probe(32'h40, 1'b0, "abort_no_line");
    access(32'h40, 0, 0);

    // iflush on the final-word cycle wins over the line write.
    pulse_flush();
    imemREN = 1'b1; imemaddr = 32'h80;
    #1;
    chk("fl_final_miss", ihit, 1'b0);
    tick();
    iload = mem_word(32'h80);
    tick();
    iload = mem_word(32'h84); iflush = 1'b1;
    #1;
    chk("fl_final_iaddr", iaddr, 32'h84);
    tick();
    iflush = 1'b0; imemREN = 1'b0;
    #1;
    chk("fl_final_iren", iREN, 1'b0);
    probe(32'h80, 1'b0, "fl_final_no_line");
    access(32'h80, 0, 0);

    // Asynchronous reset in the middle of a fill.
    imemREN = 1'b1; imemaddr = 32'hC8;
    #1;
    chk("arst_miss", ihit, 1'b0);
    tick();
    chk("arst_in_fill", iREN, 1'b1);
    imemaddr = 32'h80;
    #1;
    chk("arst_pre_hit", ihit, 1'b1);
    nRST = 1'b0;
    #1;
    chk("arst_iren", iREN, 1'b0);
    chk("arst_iaddr", iaddr, 32'h0);
    chk("arst_ihit", ihit, 1'b0);
    imemREN = 1'b0;
    tick();
    nRST = 1'b1;
    model_clear();
    tick();
    probe(32'h80, 1'b0, "arst_80_gone");
    probe(32'hC8, 1'b0, "arst_C8_none");

    // Randomized traffic over a few tags per set.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(29, 0));
      if (r == 0) pulse_flush();
      else if (r == 1) tick();
      else begin
        a = (32'($urandom_range(5, 0)) << 6) | (32'($urandom_range(15, 0)) << 2);
        access(a, 0, 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
